// File: rtl/jdec_pkg.sv
// Shared types and constants for the JPEG bitstream unpacker.
// Exports the destuff FSM states, the word register bundle and marker codes.
package jdec_pkg;

  typedef enum logic [1:0] {
    DATA,
    FF_SEEN,
    MARKER
  } jdec_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  last_idx;
    logic        last;
  } jdec_word_t;

  localparam logic [7:0] JPEG_EOI   = 8'hD9;
  localparam logic [7:0] JPEG_RST0  = 8'hD0;
  localparam logic [7:0] JPEG_STUFF = 8'h00;
  localparam logic [7:0] JPEG_FF    = 8'hFF;

  function automatic logic [7:0] word_byte(
    input logic [31:0] w,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    unique case (idx)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jdec_bitbuf.sv
// MSB-first bit buffer: appends bytes behind the oldest bits, drops consumed bits.
// Ports: consume, append(byte, pad tag), flush of pad bits, 32-bit window, real-bit count.
module jdec_bitbuf #(
  parameter int BUF_W = 64,
  parameter int FW    = $clog2(BUF_W + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          consume_valid,
  input  logic [5:0]    consume_len,
  input  logic          append_valid,
  input  logic [7:0]    append_byte,
  input  logic          append_pad,
  input  logic          flush,
  output logic [31:0]   win,
  output logic [5:0]    win_bits,
  output logic [FW-1:0] real_fill,
  output logic          space_ok
);

  localparam int SPACE_MAX = BUF_W - 8;

  logic [BUF_W-1:0] bits_q, bits_n;
  logic [BUF_W-1:0] shifted, placed, keep;
  logic [FW-1:0]    fill_q, fill_n, fill_c;
  logic [FW-1:0]    real_q, real_n, real_c;
  logic [FW-1:0]    take;
  logic             do_app;

  assign take     = consume_valid ? FW'(consume_len) : '0;
  assign fill_c   = fill_q - take;
  // Consumed bits are always the oldest, so real bits go first.
  assign real_c   = (real_q > take) ? (real_q - take) : '0;
  assign space_ok = (fill_c <= FW'(SPACE_MAX));
  assign do_app   = append_valid & space_ok & ~flush;

  assign shifted = bits_q << take;
  assign placed  = {append_byte, {(BUF_W-8){1'b0}}} >> fill_c;
  assign keep    = ~({BUF_W{1'b1}} >> real_c);

  always_comb begin
    bits_n = shifted;
    fill_n = fill_c;
    real_n = real_c;
    if (flush) begin
      bits_n = shifted & keep;
      fill_n = real_c;
    end else if (do_app) begin
      bits_n = shifted | placed;
      fill_n = fill_c + FW'(8);
      if (!append_pad) real_n = real_c + FW'(8);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bits_q <= '0;
      fill_q <= '0;
      real_q <= '0;
    end else begin
      bits_q <= bits_n;
      fill_q <= fill_n;
      real_q <= real_n;
    end
  end

  assign win       = bits_q[BUF_W-1 -: 32];
  assign win_bits  = (fill_q >= FW'(32)) ? 6'd32 : fill_q[5:0];
  assign real_fill = real_q;

endmodule

// File: rtl/jdec_bit_unpack.sv
// JPEG entropy-data unpacker: word register, 0xFF00 destuffing, marker detect.
// Ports: in_* word stream, win/win_bits peek, consume_*, marker_*, eos, size. Macro JDEC_UNPACK_PAD_EN.
module jdec_bit_unpack
  import jdec_pkg::*;
#(
  parameter int BUF_W  = 64,
  parameter int SIZE_W = 20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       in_data,
  input  logic [2:0]        in_bytes,
  input  logic              in_tlast,
  input  logic              in_valid,
  output logic              in_hold,
  output logic [31:0]       win,
  output logic [5:0]        win_bits,
  input  logic [5:0]        consume_len,
  input  logic              consume_valid,
  output logic              marker_valid,
  output logic [7:0]        marker_code,
  input  logic              marker_ack,
  output logic              eos,
  output logic [SIZE_W-1:0] size
);

  localparam int FW = $clog2(BUF_W + 1);

  jdec_word_t  wq;
  logic        wvalid;
  logic [1:0]  bidx;
  jdec_state_e st;
  logic        done;

  logic [7:0]  cur;
  logic [2:0]  nbm1;
  logic        space_ok;
  logic        proc, fin, xfer;
  logic        app, pad, flush;
  logic [7:0]  app_byte;
  logic [FW-1:0] real_fill;

  assign cur  = word_byte(wq.data, bidx);
  assign nbm1 = in_bytes - 3'd1;

  assign proc    = wvalid & ~marker_valid & space_ok;
  assign fin     = proc & (bidx == wq.last_idx);
  // Releasing on the final byte lets the next word load without a bubble.
  assign in_hold = wvalid & ~fin;
  assign xfer    = in_valid & ~in_hold;

  always_comb begin
    app      = 1'b0;
    app_byte = cur;
    if (proc) begin
      unique case (st)
        DATA: app = (cur != JPEG_FF);
        FF_SEEN: begin
          if (cur == JPEG_STUFF) begin
            app      = 1'b1;
            app_byte = JPEG_FF;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef JDEC_UNPACK_PAD_EN
  // 1-bit fill keeps the lookahead fed while intake is stopped.
  assign flush = (marker_valid & marker_ack) | (done & xfer);
  assign pad   = (marker_valid | done) & ~flush & ~proc;
`else
  assign flush = 1'b0;
  assign pad   = 1'b0;
`endif

  jdec_bitbuf #(
    .BUF_W (BUF_W),
    .FW    (FW)
  ) u_bitbuf (
    .clk           (clk),
    .resetn        (resetn),
    .consume_valid (consume_valid),
    .consume_len   (consume_len),
    .append_valid  (app | pad),
    .append_byte   (pad ? JPEG_FF : app_byte),
    .append_pad    (pad),
    .flush         (flush),
    .win           (win),
    .win_bits      (win_bits),
    .real_fill     (real_fill),
    .space_ok      (space_ok)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wq     <= '0;
      wvalid <= 1'b0;
      bidx   <= '0;
    end else if (xfer) begin
      wq.data     <= in_data;
      wq.last     <= in_tlast;
      wq.last_idx <= in_tlast ? nbm1[1:0] : 2'd3;
      wvalid      <= 1'b1;
      bidx        <= '0;
    end else if (fin) begin
      wvalid <= 1'b0;
    end else if (proc) begin
      bidx <= bidx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st           <= DATA;
      marker_valid <= 1'b0;
      marker_code  <= '0;
    end else if (proc) begin
      unique case (st)
        DATA: if (cur == JPEG_FF) st <= FF_SEEN;
        FF_SEEN: begin
          unique case (1'b1)
            (cur == JPEG_STUFF): st <= DATA;
            (cur == JPEG_FF):    st <= FF_SEEN;
            default: begin
              st           <= MARKER;
              marker_valid <= 1'b1;
              marker_code  <= cur;
            end
          endcase
        end
        default: ;
      endcase
    end else if (marker_valid && marker_ack) begin
      st           <= DATA;
      marker_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done <= 1'b0;
      size <= '0;
    end else begin
      if (proc) size <= size + SIZE_W'(1);
      if (xfer) done <= 1'b0;
      else if (fin && wq.last) done <= 1'b1;
    end
  end

  // A pending EOI must be acknowledged before the scan is reported over.
  assign eos = done & ~marker_valid & (real_fill == '0);

endmodule

// File: tb/tb_jdec_bit_unpack.sv
// Directed self-checking bench for jdec_bit_unpack.
// Each task drives one scenario and compares against hand-computed values.
module tb_jdec_bit_unpack;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0]  in_bytes = 3'd4;
  logic        in_tlast = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_hold;
  logic [31:0] win;
  logic [5:0]  win_bits;
  logic [5:0]  consume_len = 6'd8;
  logic        consume_valid = 1'b0;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        marker_ack = 1'b0;
  logic        eos;
  logic [19:0] size;

  int checks = 0;
  int errors = 0;

  jdec_bit_unpack #(.BUF_W(64), .SIZE_W(20)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_data       (in_data),
    .in_bytes      (in_bytes),
    .in_tlast      (in_tlast),
    .in_valid      (in_valid),
    .in_hold       (in_hold),
    .win           (win),
    .win_bits      (win_bits),
    .consume_len   (consume_len),
    .consume_valid (consume_valid),
    .marker_valid  (marker_valid),
    .marker_code   (marker_code),
    .marker_ack    (marker_ack),
    .eos           (eos),
    .size          (size)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn && consume_valid &&
        (consume_len == 6'd0 || consume_len > win_bits)) begin
      $display("FAIL illegal_consume: len=%0d win_bits=%0d", consume_len, win_bits);
      $fatal(1, "illegal consume");
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    consume_valid = 1'b0;
    marker_ack = 1'b0;
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(1);
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] nb,
                      input logic last, output int waited);
    in_data  = d;
    in_bytes = nb;
    in_tlast = last;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (in_hold && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_tlast = 1'b0;
    if (waited >= 100) begin
      errors++;
      $display("FAIL send_timeout: word %h never accepted", d);
    end
  endtask

  task automatic consume(input logic [5:0] len);
    consume_len = len;
    consume_valid = 1'b1;
    @(posedge clk);
    #1;
    consume_valid = 1'b0;
  endtask

  task automatic ack();
    marker_ack = 1'b1;
    @(posedge clk);
    #1;
    marker_ack = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle(1);
    checks++;
    if ({in_hold, marker_valid, eos} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {in_hold, marker_valid, eos});
    end
    checks++;
    if (win !== 32'h0 || win_bits !== 6'd0) begin
      errors++;
      $display("FAIL reset_win: got %h/%0d want 0/0", win, win_bits);
    end
    checks++;
    if (marker_code !== 8'h00 || size !== 20'd0) begin
      errors++;
      $display("FAIL reset_code_size: got %h/%0d want 0/0", marker_code, size);
    end
    resetn = 1'b1;
    idle(1);
    ack();
    idle(1);
    checks++;
    if (marker_valid !== 1'b0 || in_hold !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: got mv=%b hold=%b want 0 0", marker_valid, in_hold);
    end
  endtask

  task automatic test_basic();
    int w;
    logic [31:0] exp_win [4];
    logic [5:0]  exp_bits [4];
    exp_win  = '{32'h34567800, 32'h56780000, 32'h78000000, 32'h00000000};
    exp_bits = '{6'd24, 6'd16, 6'd8, 6'd0};
    do_reset();
    send(32'h12345678, 3'd4, 1'b0, w);
    idle(6);
    checks++;
    if (win !== 32'h12345678 || win_bits !== 6'd32) begin
      errors++;
      $display("FAIL basic_fill: got %h/%0d want 12345678/32", win, win_bits);
    end
    checks++;
    if (size !== 20'd4) begin
      errors++;
      $display("FAIL basic_size: got %0d want 4", size);
    end
    for (int i = 0; i < 4; i++) begin
      consume(6'd8);
      checks++;
      if (win !== exp_win[i] || win_bits !== exp_bits[i]) begin
        errors++;
        $display("FAIL basic_consume%0d: got %h/%0d want %h/%0d",
                 i, win, win_bits, exp_win[i], exp_bits[i]);
      end
    end
    checks++;
    if (eos !== 1'b0) begin
      errors++;
      $display("FAIL basic_eos: got %b want 0", eos);
    end
  endtask

  task automatic test_stuffing();
    int w;
    do_reset();
    send(32'hABFF00CD, 3'd4, 1'b0, w);
    idle(6);
    checks++;
    if (win !== 32'hABFFCD00 || win_bits !== 6'd24) begin
      errors++;
      $display("FAIL stuff_win: got %h/%0d want abffcd00/24", win, win_bits);
    end
    checks++;
    if (size !== 20'd4) begin
      errors++;
      $display("FAIL stuff_size: got %0d want 4", size);
    end
  endtask

  task automatic test_marker_mid_word();
    int w;
    do_reset();
    send(32'h11FFD022, 3'd4, 1'b0, w);
    idle(6);
    checks++;
    if (marker_valid !== 1'b1 || marker_code !== 8'hD0) begin
      errors++;
      $display("FAIL rst_marker: got %b/%h want 1/d0", marker_valid, marker_code);
    end
    checks++;
    if (in_hold !== 1'b1 || size !== 20'd3) begin
      errors++;
      $display("FAIL rst_stall: got hold=%b size=%0d want 1/3", in_hold, size);
    end
    checks++;
    if (win[31:24] !== 8'h11) begin
      errors++;
      $display("FAIL rst_win: got %h want 11xxxxxx", win);
    end
`ifndef JDEC_UNPACK_PAD_EN
    checks++;
    if (win_bits !== 6'd8) begin
      errors++;
      $display("FAIL rst_bits: got %0d want 8", win_bits);
    end
`endif
    consume(6'd8);
    ack();
    idle(3);
    checks++;
    if (marker_valid !== 1'b0 || in_hold !== 1'b0 || size !== 20'd4) begin
      errors++;
      $display("FAIL rst_resume: got mv=%b hold=%b size=%0d want 0/0/4",
               marker_valid, in_hold, size);
    end
    checks++;
    if (win !== 32'h22000000 || win_bits !== 6'd8) begin
      errors++;
      $display("FAIL rst_after: got %h/%0d want 22000000/8", win, win_bits);
    end
  endtask

  task automatic test_eoi_pad();
    int w;
    do_reset();
    send(32'hABFFD900, 3'd3, 1'b1, w);
    idle(8);
    checks++;
    if (marker_valid !== 1'b1 || marker_code !== 8'hD9) begin
      errors++;
      $display("FAIL eoi_marker: got %b/%h want 1/d9", marker_valid, marker_code);
    end
`ifdef JDEC_UNPACK_PAD_EN
    checks++;
    if (win !== 32'hABFFFFFF || win_bits !== 6'd32) begin
      errors++;
      $display("FAIL eoi_pad: got %h/%0d want abffffff/32", win, win_bits);
    end
`else
    checks++;
    if (win !== 32'hAB000000 || win_bits !== 6'd8) begin
      errors++;
      $display("FAIL eoi_nopad: got %h/%0d want ab000000/8", win, win_bits);
    end
`endif
    consume(6'd8);
    idle(1);
    checks++;
    if (eos !== 1'b0) begin
      errors++;
      $display("FAIL eoi_eos_early: got %b want 0", eos);
    end
    ack();
    checks++;
    if (eos !== 1'b1 || marker_valid !== 1'b0) begin
      errors++;
      $display("FAIL eoi_eos: got eos=%b mv=%b want 1/0", eos, marker_valid);
    end
`ifndef JDEC_UNPACK_PAD_EN
    checks++;
    if (win_bits !== 6'd0) begin
      errors++;
      $display("FAIL eoi_bits: got %0d want 0", win_bits);
    end
`endif
    checks++;
    if (size !== 20'd3) begin
      errors++;
      $display("FAIL eoi_size: got %0d want 3", size);
    end
  endtask

  task automatic test_tlast();
    int w;
    do_reset();
    send(32'hCAFE0000, 3'd2, 1'b1, w);
    idle(4);
    checks++;
    if (win[31:16] !== 16'hCAFE || eos !== 1'b0 || size !== 20'd2) begin
      errors++;
      $display("FAIL tlast_fill: got %h eos=%b size=%0d want cafe/0/2", win, eos, size);
    end
`ifndef JDEC_UNPACK_PAD_EN
    checks++;
    if (win_bits !== 6'd16) begin
      errors++;
      $display("FAIL tlast_bits: got %0d want 16", win_bits);
    end
`endif
    consume(6'd16);
    checks++;
    if (eos !== 1'b1) begin
      errors++;
      $display("FAIL tlast_eos: got %b want 1", eos);
    end
    send(32'h01020304, 3'd4, 1'b0, w);
    idle(6);
    checks++;
    if (eos !== 1'b0 || win !== 32'h01020304 || win_bits !== 6'd32) begin
      errors++;
      $display("FAIL tlast_restart: got eos=%b %h/%0d want 0 01020304/32",
               eos, win, win_bits);
    end
  endtask

  task automatic test_back_to_back();
    int wa, wb;
    do_reset();
    send(32'h010203FF, 3'd4, 1'b0, wa);
    send(32'h00040506, 3'd4, 1'b0, wb);
    checks++;
    if (wb !== 3) begin
      errors++;
      $display("FAIL b2b_nobubble: got %0d hold cycles want 3", wb);
    end
    idle(6);
    checks++;
    if (win !== 32'h010203FF || win_bits !== 6'd32 || size !== 20'd8) begin
      errors++;
      $display("FAIL b2b_win: got %h/%0d size=%0d want 010203ff/32/8",
               win, win_bits, size);
    end
    consume(6'd32);
    checks++;
    if (win !== 32'h04050600 || win_bits !== 6'd24) begin
      errors++;
      $display("FAIL b2b_tail: got %h/%0d want 04050600/24", win, win_bits);
    end
  endtask

  task automatic test_consume5();
    logic [103:0] golden;
    logic [99:0]  col;
    logic [31:0]  words [4];
    int got;
    int cyc;
    golden = 104'h12FF3456789AFFBCDEF00FFFAA;
    words  = '{32'h12FF0034, 32'h56789AFF, 32'h00BCDEF0, 32'h0FFF00AA};
    col = '0;
    got = 0;
    cyc = 0;
    do_reset();
    fork
      begin
        int w;
        for (int i = 0; i < 4; i++) begin
          send(words[i], 3'd4, 1'b0, w);
          idle(1);
        end
      end
      begin
        while (got < 20 && cyc < 600) begin
          consume_len = 6'd5;
          consume_valid = (win_bits >= 6'd5);
          if (consume_valid) begin
            col = {col[94:0], win[31:27]};
            got++;
          end
          @(posedge clk);
          #1;
          cyc++;
        end
        consume_valid = 1'b0;
      end
    join
    checks++;
    if (got != 20) begin
      errors++;
      $display("FAIL c5_timeout: got %0d consumes want 20", got);
    end
    checks++;
    if (col !== golden[103:4]) begin
      errors++;
      $display("FAIL c5_stream: got %h want %h", col, golden[103:4]);
    end
    checks++;
    if (size !== 20'd16 || win_bits !== 6'd4 || win[31:28] !== 4'hA) begin
      errors++;
      $display("FAIL c5_left: got size=%0d bits=%0d win=%h want 16/4/axxxxxxx",
               size, win_bits, win);
    end
  endtask

  task automatic test_async_reset();
    int w;
    do_reset();
    send(32'h12345678, 3'd4, 1'b0, w);
    idle(1);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (win_bits !== 6'd0 || size !== 20'd0 || in_hold !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got bits=%0d size=%0d hold=%b want 0/0/0",
               win_bits, size, in_hold);
    end
    idle(1);
    resetn = 1'b1;
    idle(4);
    checks++;
    if (win_bits !== 6'd0 || size !== 20'd0) begin
      errors++;
      $display("FAIL async_discard: got bits=%0d size=%0d want 0/0", win_bits, size);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuffing();
    test_marker_mid_word();
    test_eoi_pad();
    test_tlast();
    test_back_to_back();
    test_consume5();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
